// File: rtl/pdm_stereo_tx.sv
// rtl/pdm_stereo_tx.sv - stereo PDM transmitter with per-channel first-order sigma-delta modulators
module pdm_stereo_tx #(
    parameter int PCM_BITS = 16,
    parameter int OSR_LOG2 = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic [PCM_BITS-1:0] pcm_left,
    input  logic [PCM_BITS-1:0] pcm_right,
    input  logic                pcm_valid,
    output logic                pcm_ready,
    output logic                pdm_clk,
    output logic                pdm_data,
    output logic                underrun
);

    // Accumulator carries two guard bits so acc stays in [-2FS, 2FS-2] without saturation.
    localparam int AW = PCM_BITS + 2;
    localparam logic signed [AW-1:0] FS_POS = {2'b00, 1'b1, {(PCM_BITS-1){1'b0}}};
    localparam logic signed [AW-1:0] FS_NEG = -FS_POS;

    logic [6:0]            hcnt_q, hcnt_d;
    logic [OSR_LOG2-1:0]   pcnt_q;
    logic                  pdm_clk_q, pdm_data_q, underrun_q;
    logic                  hold_full_q, hold_full_d;
    logic                  mode_q, started_q;
    logic [PCM_BITS-1:0]   hold_l_q, hold_r_q, active_l_q, active_r_q;
    logic signed [AW-1:0]  acc_l_q, acc_r_q, acc_l_d, acc_r_d;
    logic signed [AW-1:0]  x_l, x_r;
    logic                  tick, rise, fall, boundary, load, xfer, mode_eff;
    logic                  bit_l, bit_r;

    function automatic logic signed [AW-1:0] sext(input logic [PCM_BITS-1:0] v);
        return $signed({{2{v[PCM_BITS-1]}}, v});
    endfunction

    assign tick     = (hcnt_q == 7'd0);
    assign rise     = tick & ~pdm_clk_q;
    assign fall     = tick & pdm_clk_q;
    assign boundary = rise & (pcnt_q == '0);
    // Consumption looks at the holding state from the start of the cycle; no bypass.
    assign load     = boundary & hold_full_q;
    assign xfer     = pcm_valid & ~hold_full_q;
    // The rate captured at a boundary already governs the half period that starts there.
    assign mode_eff = boundary ? mode : mode_q;
    assign bit_l    = ~acc_l_q[AW-1];
    assign bit_r    = ~acc_r_q[AW-1];

    assign pcm_ready = ~hold_full_q;
    assign pdm_clk   = pdm_clk_q;
    assign pdm_data  = pdm_data_q;
    assign underrun  = underrun_q;

    // Next-state for the half-period counter, holding flag and both modulators.
    always_comb begin
        hcnt_d = hcnt_q - 7'd1;
        if (tick) begin
            hcnt_d = mode_eff ? 7'd31 : 7'd63;
        end
        hold_full_d = hold_full_q;
        if (xfer) begin
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
        x_l = load ? sext(hold_l_q) : sext(active_l_q);
        x_r = sext(active_r_q);
        acc_l_d = acc_l_q;
        if (rise) begin
            acc_l_d = acc_l_q + x_l + (bit_l ? FS_NEG : FS_POS);
        end
        acc_r_d = acc_r_q;
        if (fall) begin
            acc_r_d = acc_r_q + x_r + (bit_r ? FS_NEG : FS_POS);
        end
    end

    // Bit clock generation: half-period countdown, toggle, period count, rate capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q    <= 7'd0;
            pdm_clk_q <= 1'b0;
            pcnt_q    <= '0;
            mode_q    <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            if (tick) begin
                pdm_clk_q <= ~pdm_clk_q;
            end
            if (rise) begin
                pcnt_q <= pcnt_q + 1'b1;
            end
            if (boundary) begin
                mode_q <= mode;
            end
        end
    end

    // Sample path: holding register, frame-boundary load, started flag and underrun pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            active_l_q  <= '0;
            active_r_q  <= '0;
            started_q   <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            if (xfer) begin
                hold_l_q <= pcm_left;
                hold_r_q <= pcm_right;
            end
            if (load) begin
                active_l_q <= hold_l_q;
                active_r_q <= hold_r_q;
            end
            started_q  <= started_q | xfer;
            underrun_q <= boundary & ~hold_full_q & started_q;
        end
    end

    // Modulator state and the shared data wire: left bit on rise, right bit on fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            pdm_data_q <= 1'b0;
        end else begin
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            if (rise) begin
                pdm_data_q <= bit_l;
            end else if (fall) begin
                pdm_data_q <= bit_r;
            end
        end
    end

endmodule

// File: tb/tb_pdm_stereo_tx.sv
// tb/tb_pdm_stereo_tx.sv - randomized self-checking bench for pdm_stereo_tx against a behavioural model
module tb_pdm_stereo_tx;

    localparam int FS = 32768;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic [15:0] pcm_left = '0;
    logic [15:0] pcm_right = '0;
    logic        pcm_valid = 1'b0;
    logic        pcm_ready, pdm_clk, pdm_data, underrun;

    always #5 clk = ~clk;

    pdm_stereo_tx #(.PCM_BITS(16), .OSR_LOG2(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .pcm_left  (pcm_left),
        .pcm_right (pcm_right),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .pdm_clk   (pdm_clk),
        .pdm_data  (pdm_data),
        .underrun  (underrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: absolute-time edge schedule, integer accumulators, one-slot holding store.
    int  m_cyc, m_next, m_rises, m_frames;
    int  m_hl, m_hr, m_al, m_ar, m_accl, m_accr;
    bit  m_clk, m_data, m_under, m_mode, m_hfull, m_started;
    bit  mx, mbit;

    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cyc = 0; m_next = 0; m_rises = 0; m_frames = 0;
            m_hl = 0; m_hr = 0; m_al = 0; m_ar = 0; m_accl = 0; m_accr = 0;
            m_clk = 0; m_data = 0; m_under = 0; m_mode = 0; m_hfull = 0; m_started = 0;
        end else begin
            mx = pcm_valid && !m_hfull;
            m_under = 0;
            if (m_cyc == m_next) begin
                if (!m_clk) begin
                    if ((m_rises % 64) == 0) begin
                        m_frames++;
                        m_mode = mode;
                        if (m_hfull) begin
                            m_al = m_hl; m_ar = m_hr; m_hfull = 0;
                        end else if (m_started) begin
                            m_under = 1;
                        end
                    end
                    mbit = (m_accl >= 0);
                    m_accl = m_accl + m_al - (mbit ? FS : -FS);
                    m_data = mbit; m_clk = 1; m_rises++;
                end else begin
                    mbit = (m_accr >= 0);
                    m_accr = m_accr + m_ar - (mbit ? FS : -FS);
                    m_data = mbit; m_clk = 0;
                end
                m_next = m_cyc + (m_mode ? 32 : 64);
            end
            if (mx) begin
                m_hl = int'($signed(pcm_left));
                m_hr = int'($signed(pcm_right));
                m_hfull = 1; m_started = 1;
            end
            m_cyc++;
        end
    end

    // Monitor: per-cycle comparison plus per-frame statistics of the DUT bitstream.
    int  ones_l [64], ones_r [64], und_at [64], xfer_at [64];
    int  glitch = 0, acc_viol = 0, fr, acc_now;
    bit  prev_clk = 0, prev_data = 0;

    always begin
        @(negedge clk);
        fr = (m_rises - 1) / 64;
        if (fr < 0) fr = 0;
        if (fr > 63) fr = 63;
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                ones_l[i] = 0; ones_r[i] = 0; und_at[i] = 0; xfer_at[i] = 0;
            end
        end else begin
            check_val("pdm_clk", pdm_clk, m_clk);
            check_val("pdm_data", pdm_data, m_data);
            check_val("underrun", underrun, m_under);
            check_val("pcm_ready", pcm_ready, !m_hfull);
            if (pdm_data != prev_data && pdm_clk == prev_clk) glitch++;
            if (pdm_clk && !prev_clk) ones_l[fr] += pdm_data;
            if (!pdm_clk && prev_clk) ones_r[fr] += pdm_data;
            if (underrun) und_at[fr]++;
            if (pcm_valid && pcm_ready) xfer_at[fr]++;
            acc_now = int'(dut.acc_l_q);
            if (acc_now > 65534 || acc_now < -65536) acc_viol++;
        end
        prev_clk = pdm_clk;
        prev_data = pdm_data;
    end

    task automatic wait_boundary(input int bound);
        int start = m_frames;
        int n = 0;
        while (m_frames == start && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (m_frames == start) check_val("boundary_timeout", 0, 1);
    endtask

    task automatic measure_period(output int p);
        int n = 0;
        int w = 0;
        while (pdm_clk !== 1'b0 && w < 300) begin @(negedge clk); w++; end
        while (pdm_clk !== 1'b1 && w < 600) begin @(negedge clk); w++; end
        do begin @(negedge clk); n++; end while (pdm_clk !== 1'b0 && n < 300);
        do begin @(negedge clk); n++; end while (pdm_clk !== 1'b1 && n < 600);
        p = n;
    endtask

    int p;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_pdm_clk", pdm_clk, 0);
        check_val("reset_pdm_data", pdm_data, 0);
        check_val("reset_underrun", underrun, 0);
        check_val("reset_pcm_ready", pcm_ready, 1);
        rst = 1'b0;

        // Frame 0: mode 0, no source; rate request changes mid-frame.
        measure_period(p);
        check_val("period_mode0", p, 128);
        repeat (4000) @(posedge clk);
        #1 mode = 1'b1;
        measure_period(p);
        check_val("period_before_boundary", p, 128);
        repeat (2000) @(posedge clk);
        #1;
        pcm_valid = 1'b1; pcm_left = 16'h0000; pcm_right = 16'h0000;
        wait_boundary(9000);                                   // b1: 0/0 active
        pcm_left = 16'h4000; pcm_right = 16'hC000;
        measure_period(p);
        check_val("period_after_boundary", p, 64);
        wait_boundary(9000);                                   // b2
        wait_boundary(9000);                                   // b3
        pcm_left = 16'h8000; pcm_right = 16'h0000;
        wait_boundary(9000);                                   // b4
        wait_boundary(9000);                                   // b5
        pcm_left = 16'h7FFF; pcm_right = 16'h7FFF;
        wait_boundary(9000);                                   // b6
        for (int k = 7; k <= 9; k++) begin
            wait_boundary(9000);
            pcm_left = 16'($urandom); pcm_right = 16'($urandom);
        end
        wait_boundary(9000);                                   // b10: random valid
        for (int n = 0; n < 5000 && m_frames == 11; n++) begin
            pcm_valid = ($urandom_range(0, 7) == 0);
            pcm_left = 16'($urandom); pcm_right = 16'($urandom);
            @(posedge clk); #1;
        end
        pcm_valid = 1'b1; pcm_left = 16'h1234; pcm_right = 16'hEDCB;
        @(posedge clk); #1;
        pcm_valid = 1'b0;
        wait_boundary(9000);                                   // b12
        wait_boundary(9000);                                   // b13
        wait_boundary(9000);                                   // b14
        repeat (3) @(posedge clk);
        #1;

        check_val("zero_ones_l_f0", ones_l[0], 32);
        check_val("zero_ones_r_f0", ones_r[0], 32);
        check_val("zero_ones_l_f1", ones_l[1], 32);
        check_val("zero_ones_r_f1", ones_r[1], 32);
        check_val("half_pos_ones_l_f2", ones_l[2], 48);
        check_val("half_neg_ones_r_f2", ones_r[2], 16);
        check_val("half_pos_ones_l_f3", ones_l[3], 48);
        check_val("half_neg_ones_r_f3", ones_r[3], 16);
        check_val("neg_full_ones_l_f4", ones_l[4], 1);
        check_val("neg_full_ones_l_f5", ones_l[5], 0);
        check_val("pos_full_ones_l_f7", int'(ones_l[7] >= 63), 1);
        check_val("pos_full_ones_r_f7", int'(ones_r[7] >= 63), 1);
        check_val("xfer_per_frame_7", xfer_at[7], 1);
        check_val("xfer_per_frame_8", xfer_at[8], 1);
        check_val("xfer_per_frame_9", xfer_at[9], 1);
        check_val("no_underrun_before_start", und_at[0], 0);
        check_val("no_underrun_f12", und_at[12], 0);
        check_val("underrun_f13", und_at[13], 1);
        check_val("underrun_f14", und_at[14], 1);

        // Mid-frame reset with a pending sample in the holding register.
        pcm_valid = 1'b1; pcm_left = 16'h4000; pcm_right = 16'h4000;
        @(posedge clk); #1;
        pcm_valid = 1'b0;
        repeat (100) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_val("midreset_pdm_clk", pdm_clk, 0);
        check_val("midreset_pdm_data", pdm_data, 0);
        check_val("midreset_pcm_ready", pcm_ready, 1);
        check_val("midreset_underrun", underrun, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_boundary(9000);                                   // b0 after reset
        wait_boundary(9000);                                   // b1 after reset
        repeat (3) @(posedge clk);
        #1;
        check_val("post_reset_no_underrun_b1", und_at[1], 0);
        check_val("post_reset_discard_l", ones_l[0], 32);
        check_val("post_reset_discard_r", ones_r[0], 32);
        check_val("data_only_on_clk_edge", glitch, 0);
        check_val("acc_l_range", acc_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
